// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the pipeline control blocks.
//   mdu_state_e : multiply/divide unit sequencer states (IDLE, BUSY)
//   REG_ZERO    : index of the hard-wired zero register ($zero)
//   CNT_W       : width of the MDU latency down-counter
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int REG_ZERO = 0;
  localparam int CNT_W    = 8;

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating performance counters for the hazard unit.
// Only built when HAZARD_PERF_EN is defined.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (clears counters)
//   stall        : pipeline stall asserted this cycle
//   ifid_flush   : IF/ID flush asserted this cycle
//   stall_cycles : number of stalled cycles since reset (saturating)
//   flush_count  : number of IF/ID flush cycles since reset (saturating)
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ifid_flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  logic [31:0] stall_cycles_r;
  logic [31:0] flush_count_r;

  // Count stalled cycles and flush cycles; both stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_r <= 32'd0;
      flush_count_r  <= 32'd0;
    end else begin
      if (stall && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (ifid_flush && (flush_count_r != 32'hFFFF_FFFF)) begin
        flush_count_r <= flush_count_r + 32'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard control for a 5-stage MIPS core.
// Detects load-use hazards (purely combinational) and multiply/divide
// unit (MDU) occupancy hazards (IDLE/BUSY sequencer with a down-counter),
// and produces PC / IF-ID / ID-EX enables and flushes in the same cycle.
// Optional macro HAZARD_PERF_EN adds stall/flush performance counters.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   id_rs, id_rt        : source specifiers of the instruction in ID
//   id_uses_rt          : ID instruction reads rt
//   ex_rt, ex_mem_read  : destination and load flag of the instruction in EX
//   branch_taken        : branch/jump resolved taken in ID
//   mdu_start           : ID instruction is mult/multu/div/divu
//   id_hilo_read        : ID instruction is mfhi/mflo
//   pc_en, ifid_en      : PC and IF/ID enables
//   ifid_flush          : IF/ID synchronous clear
//   idex_flush          : ID/EX clear (bubble)
//   mdu_busy            : MDU occupied
//   stall_cycles, flush_count : perf counters (HAZARD_PERF_EN only)
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             id_hilo_read,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  mdu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;

  logic lu_s;
  logic mh_s;
  logic stall_s;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // $zero is never a real dependency.
  assign lu_s = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // MDU hazard: HI/LO read or a second MDU op while the unit is occupied.
  assign mh_s    = (state_r == BUSY) && (id_hilo_read || mdu_start);
  assign stall_s = lu_s || mh_s;

  // MDU sequencer: count MDU_LAT cycles of occupancy after an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // A start that is itself stalled by a load-use is not accepted.
          if (mdu_start && !stall_s) begin
            state_r <= BUSY;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
            busy_r  <= 1'b0;
          end
        end
        BUSY: begin
          // A new mdu_start here is stalled, never reloads the counter.
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= IDLE;
            cnt_r   <= cnt_r;
            busy_r  <= 1'b0;
          end else begin
            state_r <= BUSY;
            cnt_r   <= cnt_r - CNT_W'(1);
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_busy = busy_r;

  // Pipeline control; stall has priority over a taken branch, which
  // re-resolves once ID is released.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall_s) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b0;
    end else begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_perf (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall_s),
    .ifid_flush   (ifid_flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Expected output vectors
// {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy} come from a small
// cycle model (remaining-busy-cycles counter) and are queued when stimulus
// is driven, then popped and compared at the following falling edge.
module tb_hazard_ctrl;

  localparam int REG_W   = 5;
  localparam int MDU_LAT = 12;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic [REG_W-1:0] ex_rt;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             mdu_start;
  logic             id_hilo_read;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mdu_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;
`endif

  hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(MDU_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_rt        (ex_rt),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .mdu_start    (mdu_start),
    .id_hilo_read (id_hilo_read),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .mdu_busy     (mdu_busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] exp_q[$];
  int         busy_left = 0;   // model: remaining MDU busy cycles
  logic       m_stall   = 1'b0;
  int         busy_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the model's expectation, compare
  // at the falling edge, then advance the model on the rising edge.
  task automatic step(input string tag, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                      input logic urt, input logic [REG_W-1:0] ert, input logic emr,
                      input logic br, input logic st, input logic hl);
    logic       lu, mh;
    logic [4:0] e;
    logic [4:0] o;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_rt = ert;
    ex_mem_read = emr; branch_taken = br; mdu_start = st; id_hilo_read = hl;
    lu = emr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
    mh = (busy_left != 0) && (hl || st);
    m_stall = lu || mh;
    if (m_stall)   e = 5'b00010;
    else if (br)   e = 5'b11100;
    else           e = 5'b11000;
    e[0] = (busy_left != 0);
    exp_q.push_back(e);
    @(negedge clk);
    o = {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy};
    check_val(tag, {27'd0, o}, {27'd0, exp_q.pop_front()});
    if (mdu_busy) busy_seen++;
    @(posedge clk);
    if (busy_left != 0) busy_left--;
    else if (st && !m_stall) busy_left = MDU_LAT;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0; id_hilo_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_outs", {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy}, 32'h6);
    @(posedge clk); #1;
    reset = 1'b0;

    // Load-use on rs, then load leaves EX.
    step("lu_rs",      5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_release", 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    // $zero destination never stalls.
    step("lu_zero",    5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // rt dependency only counts when rt is read.
    step("lu_rt_used", 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rt_unused", 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    // Branch alone, then branch concurrent with load-use.
    step("branch",     5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("branch_lu",  5'd3, 5'd2, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    // A start blocked by load-use is not accepted.
    step("start_lu",   5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step("idle",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MDU occupancy: start, then mfhi from cycle 5 until released.
    busy_seen = 0;
    step("mdu_start",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step($sformatf("mdu_c%0d", i), 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
           (i == 3) ? 1'b1 : 1'b0, (i >= 5) ? 1'b1 : 1'b0);
    end
    check_val("mdu_busy_len", busy_seen, MDU_LAT);

    // Asynchronous reset mid-BUSY (counter at 6).
    step("mdu_start2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step("mdu_run", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check_val("busy_before_rst", {31'd0, mdu_busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("async_rst_outs", {27'd0, pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy}, 32'h6);
    busy_left = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    step("post_rst_idle", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           REG_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

`ifdef HAZARD_PERF_EN
    // Counters: 3 load-use stalls and 2 taken branches from reset.
    @(negedge clk);
    reset = 1'b1;
    busy_left = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("perf_lu",  5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step("perf_nop", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      step("perf_br",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("perf_nop", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_val("stall_cycles", stall_cycles, 32'd3);
    check_val("flush_count",  flush_count,  32'd2);
`endif

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
